div_sched: RTL
==============

Name: div_sched

Overview:
- Shared, multi-cycle integer divide unit serving two requesters.
- Round-robin arbitration between requesters.
- One iterative restoring divider, one quotient bit per cycle; signed and unsigned ops on the same datapath.
- Sits between issue logic and the integer result path; replaces per-client combinational udiv/sdiv instances where area matters.

Parameters:
- W, 32, operand/quotient width in bits (>=2).
- CW, 5, iteration counter width; must satisfy 2^CW >= W.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_signed  input  1  1 = signed divide, 0 = unsigned.
- req0_a  input  W  dividend.
- req0_b  input  W  divisor.
- req1_valid, req1_ready, req1_signed, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_id  output  1  requester that owns the result.
- rsp_q  output  W  quotient.
- rsp_dz  output  1  divide-by-zero flag.

Behaviour:
- Reset values (async, immediate): state=IDLE, req0_ready=0, req1_ready=0, rsp_valid=0, rsp_id=0, rsp_q=0, rsp_dz=0, counter=0, last_grant=1 (requester 0 wins the first contest).
- States: IDLE, CALC, DONE.
- req*_ready is combinational and is asserted only in IDLE, for at most one requester per cycle.
  - Grant rule: only one valid -> grant it. Both valid -> grant the requester != last_grant.
  - Accept occurs on the edge where valid&&ready. On accept: latch the operands, rsp_id and the signed flag; set last_grant.
- Accept with b==0:
  - Go directly to DONE with rsp_q=0, rsp_dz=1.
  - rsp_valid goes high the cycle after accept.
- Accept with b!=0:
  - Store |a| and |b| (magnitude taken only when signed and the MSB is set).
  - Store sign_q = a[W-1]^b[W-1] for signed ops, 0 for unsigned.
  - Clear the partial remainder; counter=W-1; go to CALC.
- CALC, each cycle:
  - rem' = {rem[W-2:0], dividend[counter]}.
  - If rem' >= divisor: subtract the divisor and set quotient bit [counter] to 1; else set it to 0.
  - Decrement the counter. At counter==0 go to DONE.
  - Exactly W CALC cycles per operation.
- Entering DONE from CALC: rsp_q = sign_q ? -quotient : quotient (W-bit two's complement); rsp_dz=0.
- Latency: rsp_valid first high W+1 cycles after the accept edge (33 for W=32); 1 cycle for divide-by-zero.
- Signed semantics: truncation toward zero. Most-negative / -1 wraps to the most-negative value (0x80000000 for W=32); no overflow flag.
- DONE:
  - rsp_valid=1; rsp_q, rsp_dz and rsp_id are held stable while rsp_ready=0.
  - On rsp_valid&&rsp_ready go to IDLE. No new request is accepted in that same cycle; the earliest next accept is the following cycle.
- Requests arriving during CALC/DONE are not accepted. Requesters must hold valid and operands stable until ready.
- req*_valid deasserted before its ready: no effect, no state change.
- Reset mid-operation (CALC or DONE): in-flight result is discarded; all outputs return to reset values immediately; last_grant=1.
- Response outputs outside DONE: rsp_valid=0; rsp_q/rsp_dz/rsp_id retain their last values.

Test Plan:
- Unsigned: req0 a=11 b=5 signed=0 -> req0_ready 1 cycle; rsp_valid 33 cycles later with rsp_q=2, rsp_dz=0, rsp_id=0.
- Signed: req1 a=-10 b=5 signed=1 -> rsp_q=0xFFFFFFFE, rsp_dz=0, rsp_id=1. Also a=-7 b=2 -> rsp_q=0xFFFFFFFD (-3, truncation).
- Divide by zero: req0 a=5 b=0 -> rsp_valid the cycle after accept, rsp_q=0, rsp_dz=1. Signed most-negative / -1 -> rsp_q=0x80000000, rsp_dz=0.
- Arbitration: both valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0. No two accepts within 34 cycles, except accepts following a divide-by-zero.
- Backpressure: rsp_ready=0 for 10 cycles in DONE -> rsp_valid, rsp_q and rsp_id stable; both ready outputs 0; on rsp_ready=1 return to IDLE, and the next accept occurs one cycle later.
- Reset: assert rst at CALC cycle 15 -> rsp_valid=0 and ready outputs=0 immediately. After release, a new req0 12/4 -> rsp_q=3 after 33 cycles.

Source files
------------

// File: rtl/div_sched.sv
// div_sched: shared iterative restoring divider serving two requesters.
// Requests are arbitrated round-robin, one quotient bit is produced per
// cycle, and signed operations reuse the unsigned datapath by working on
// operand magnitudes and fixing the quotient sign at the end.
module div_sched #(
   parameter int W  = 32,
   parameter int CW = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic         req0_signed,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic         req1_signed,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_q,
   output logic         rsp_dz
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t         r_state;
   state_t         w_nextState;

   logic           r_lastGrant;
   logic [W-1:0]   r_dividend;
   logic [W-1:0]   r_divisor;
   logic [W-1:0]   r_rem;
   logic [W-1:0]   r_quot;
   logic           r_signQ;
   logic [CW-1:0]  r_count;
   logic [W-1:0]   r_rspQ;
   logic           r_rspDz;
   logic           r_rspId;

   logic           w_grant0;
   logic           w_grant1;
   logic           w_accept;
   logic           w_selSigned;
   logic [W-1:0]   w_selA;
   logic [W-1:0]   w_selB;
   logic [W-1:0]   w_absA;
   logic [W-1:0]   w_absB;
   logic           w_selBZero;
   logic [W:0]     w_remShift;
   logic [W:0]     w_diff;
   logic           w_qBit;
   logic [W-1:0]   w_remNext;
   logic [W-1:0]   w_quotNext;
   logic [W-1:0]   w_quotSigned;

   // Round-robin grant: only offered while idle and never while reset is held
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (r_state == IDLE && !rst) begin
         if (req0_valid && (!req1_valid || r_lastGrant)) begin
            w_grant0 = 1'b1;
         end else if (req1_valid) begin
            w_grant1 = 1'b1;
         end
      end
   end

   assign w_accept    = w_grant0 | w_grant1;
   assign w_selSigned = w_grant1 ? req1_signed : req0_signed;
   assign w_selA      = w_grant1 ? req1_a : req0_a;
   assign w_selB      = w_grant1 ? req1_b : req0_b;
   assign w_selBZero  = (w_selB == '0);
   assign w_absA      = (w_selSigned && w_selA[W-1]) ? (-w_selA) : w_selA;
   assign w_absB      = (w_selSigned && w_selB[W-1]) ? (-w_selB) : w_selB;

   // One restoring step; the extra top bit keeps large unsigned divisors exact
   always_comb begin
      w_remShift   = {r_rem, r_dividend[W-1]};
      w_diff       = w_remShift - {1'b0, r_divisor};
      w_qBit       = ~w_diff[W];
      w_remNext    = w_qBit ? w_diff[W-1:0] : w_remShift[W-1:0];
      w_quotNext   = {r_quot[W-2:0], w_qBit};
      w_quotSigned = r_signQ ? (-w_quotNext) : w_quotNext;
   end

   // Next-state decode: divide-by-zero skips the iteration phase entirely
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_nextState = w_selBZero ? DONE : CALC;
            end
         end
         CALC: begin
            if (r_count == '0) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Operand capture, iteration and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lastGrant <= 1'b1;
         r_dividend  <= '0;
         r_divisor   <= '0;
         r_rem       <= '0;
         r_quot      <= '0;
         r_signQ     <= 1'b0;
         r_count     <= '0;
         r_rspQ      <= '0;
         r_rspDz     <= 1'b0;
         r_rspId     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_lastGrant <= w_grant1;
                  r_rspId     <= w_grant1;
                  if (w_selBZero) begin
                     r_rspQ  <= '0;
                     r_rspDz <= 1'b1;
                  end else begin
                     r_dividend <= w_absA;
                     r_divisor  <= w_absB;
                     r_signQ    <= w_selSigned & (w_selA[W-1] ^ w_selB[W-1]);
                     r_rem      <= '0;
                     r_quot     <= '0;
                     r_count    <= CW'(W - 1);
                  end
               end
            end
            CALC: begin
               r_rem      <= w_remNext;
               r_quot     <= w_quotNext;
               r_dividend <= {r_dividend[W-2:0], 1'b0};
               r_count    <= r_count - 1'b1;
               if (r_count == '0) begin
                  r_rspQ  <= w_quotSigned;
                  r_rspDz <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;
   assign rsp_valid  = (r_state == DONE);
   assign rsp_q      = r_rspQ;
   assign rsp_dz     = r_rspDz;
   assign rsp_id     = r_rspId;

endmodule
